// File: rtl/video_timing_gen_pkg.sv
// Shared timing constants for video_timing_gen: the default 640x480@60 mode plus the
// 800x600 and 1024x768 mode tables that instantiating modules pass in as parameters.
package video_timing_gen_pkg;

  typedef struct packed {
    int unsigned visible;
    int unsigned front;
    int unsigned sync;
    int unsigned back;
  } axis_timing_t;

  typedef struct packed {
    axis_timing_t h;
    axis_timing_t v;
    bit           hsync_pol;
    bit           vsync_pol;
  } video_mode_t;

  localparam video_mode_t MODE_640X480_60 = '{
    h: '{visible: 640, front: 16, sync: 96, back: 48},
    v: '{visible: 480, front: 10, sync: 2, back: 33},
    hsync_pol: 1'b0, vsync_pol: 1'b0
  };

  localparam video_mode_t MODE_800X600_60 = '{
    h: '{visible: 800, front: 40, sync: 128, back: 88},
    v: '{visible: 600, front: 1, sync: 4, back: 23},
    hsync_pol: 1'b1, vsync_pol: 1'b1
  };

  localparam video_mode_t MODE_1024X768_60 = '{
    h: '{visible: 1024, front: 24, sync: 136, back: 160},
    v: '{visible: 768, front: 3, sync: 6, back: 29},
    hsync_pol: 1'b0, vsync_pol: 1'b0
  };

  function automatic int unsigned axis_total(axis_timing_t t);
    return t.visible + t.front + t.sync + t.back;
  endfunction

endpackage

// File: rtl/vtg_axis_counter.sv
// One raster axis: wrapping position counter with registered sync and visible-region
// decodes that always describe the count currently held.
module vtg_axis_counter
  import video_timing_gen_pkg::*;
#(
  parameter int unsigned CNT_W   = 12,
  parameter int unsigned VISIBLE = 640,
  parameter int unsigned FRONT   = 16,
  parameter int unsigned SYNC    = 96,
  parameter int unsigned BACK    = 48,
  parameter bit          POL     = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  output logic [CNT_W-1:0] count,
  output logic             wrap,
  output logic             sync,
  output logic             vis
);

  localparam int unsigned TOTAL = axis_total('{VISIBLE, FRONT, SYNC, BACK});

  if (VISIBLE == 0 || SYNC == 0) begin : g_bad_axis
    $error("vtg_axis_counter: VISIBLE and SYNC must both be non-zero");
  end
  if (((TOTAL - 1) >> CNT_W) != 0) begin : g_bad_width
    $error("vtg_axis_counter: CNT_W=%0d cannot hold %0d", CNT_W, TOTAL - 1);
  end

  localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] VIS_LAST   = CNT_W'(VISIBLE - 1);
  localparam logic [CNT_W-1:0] SYNC_FIRST = CNT_W'(VISIBLE + FRONT);
  localparam logic [CNT_W-1:0] SYNC_LAST  = CNT_W'(VISIBLE + FRONT + SYNC - 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             sync_q, sync_d;
  logic             vis_q, vis_d;

  assign wrap = (count_q == LAST);

  // Decodes look at the next count so the flags land on the same edge as the counter.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path infers a latch.
    count_d = count_q;
    if (step) begin
      count_d = wrap ? '0 : count_q + 1'b1;
    end
    vis_d  = (count_d <= VIS_LAST);
    sync_d = ((count_d >= SYNC_FIRST) && (count_d <= SYNC_LAST)) ? POL : ~POL;
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      vis_q   <= 1'b1;
      sync_q  <= ~POL;
    end else begin
      count_q <= count_d;
      vis_q   <= vis_d;
      sync_q  <= sync_d;
    end
  end

  assign count = count_q;
  assign sync  = sync_q;
  assign vis   = vis_q;

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: sync, data-enable and line/frame strobes.
// Define VTG_XY_OUT_EN to expose h_count/v_count as output ports.
module video_timing_gen
  import video_timing_gen_pkg::*;
#(
  parameter int unsigned CNT_W     = 12,
  parameter int unsigned H_VISIBLE = MODE_640X480_60.h.visible,
  parameter int unsigned H_FRONT   = MODE_640X480_60.h.front,
  parameter int unsigned H_SYNC    = MODE_640X480_60.h.sync,
  parameter int unsigned H_BACK    = MODE_640X480_60.h.back,
  parameter int unsigned V_VISIBLE = MODE_640X480_60.v.visible,
  parameter int unsigned V_FRONT   = MODE_640X480_60.v.front,
  parameter int unsigned V_SYNC    = MODE_640X480_60.v.sync,
  parameter int unsigned V_BACK    = MODE_640X480_60.v.back,
  parameter bit          HSYNC_POL = MODE_640X480_60.hsync_pol,
  parameter bit          VSYNC_POL = MODE_640X480_60.vsync_pol
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_en,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             line_start,
  output logic             frame_start
`ifdef VTG_XY_OUT_EN
  ,
  output logic [CNT_W-1:0] h_count,
  output logic [CNT_W-1:0] v_count
`endif
);

  logic h_wrap, v_wrap, h_vis, v_vis;
  logic line_start_q, line_start_d;
  logic frame_start_q, frame_start_d;

  vtg_axis_counter #(
    .CNT_W   (CNT_W),
    .VISIBLE (H_VISIBLE),
    .FRONT   (H_FRONT),
    .SYNC    (H_SYNC),
    .BACK    (H_BACK),
    .POL     (HSYNC_POL)
  ) u_h_axis (
    .clk   (clk),
    .rst   (rst),
    .step  (pix_en),
`ifdef VTG_XY_OUT_EN
    .count (h_count),
`else
    .count (),
`endif
    .wrap  (h_wrap),
    .sync  (hsync),
    .vis   (h_vis)
  );

  vtg_axis_counter #(
    .CNT_W   (CNT_W),
    .VISIBLE (V_VISIBLE),
    .FRONT   (V_FRONT),
    .SYNC    (V_SYNC),
    .BACK    (V_BACK),
    .POL     (VSYNC_POL)
  ) u_v_axis (
    .clk   (clk),
    .rst   (rst),
    .step  (pix_en & h_wrap),
`ifdef VTG_XY_OUT_EN
    .count (v_count),
`else
    .count (),
`endif
    .wrap  (v_wrap),
    .sync  (vsync),
    .vis   (v_vis)
  );

  // A strobe marks the edge that loads h=0, so it is driven from the pre-edge wrap.
  always_comb begin
    line_start_d  = pix_en & h_wrap;
    frame_start_d = line_start_d & v_wrap;
  end

  // NOTE: reset is asynchronous so a mid-frame reset clears outputs without waiting for clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign de          = h_vis & v_vis;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen: a default 640x480 instance and a tiny 8x6 mode
// instance share clk/rst/pix_en and are checked every cycle against an arithmetic model.
module tb_video_timing_gen;

  localparam int CW = 12;

  typedef struct packed {
    logic          hs;
    logic          vs;
    logic          de;
    logic          ls;
    logic          fs;
    logic [CW-1:0] h;
    logic [CW-1:0] v;
  } obs_t;

  typedef struct {
    obs_t d;
    obs_t s;
  } exp_t;

  typedef struct {
    int hv, hf, hsw, hb;
    int vv, vf, vsw, vb;
    bit hp, vp;
  } mode_t;

  typedef struct {
    int h;
    int v;
    bit ls;
    bit fs;
  } mstate_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pix_en = 1'b0;

  logic d_hs, d_vs, d_de, d_ls, d_fs;
  logic s_hs, s_vs, s_de, s_ls, s_fs;
`ifdef VTG_XY_OUT_EN
  logic [CW-1:0] d_h, d_v, s_h, s_v;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  mode_t   m_d, m_s;
  mstate_t st_d, st_s;
  exp_t    exp_q[$];

  always #5 clk = ~clk;

  video_timing_gen u_dflt (
    .clk         (clk),
    .rst         (rst),
    .pix_en      (pix_en),
    .hsync       (d_hs),
    .vsync       (d_vs),
    .de          (d_de),
    .line_start  (d_ls),
    .frame_start (d_fs)
`ifdef VTG_XY_OUT_EN
    ,
    .h_count     (d_h),
    .v_count     (d_v)
`endif
  );

  video_timing_gen #(
    .CNT_W     (CW),
    .H_VISIBLE (4), .H_FRONT (1), .H_SYNC (2), .H_BACK (1),
    .V_VISIBLE (3), .V_FRONT (1), .V_SYNC (1), .V_BACK (1),
    .HSYNC_POL (1'b1), .VSYNC_POL (1'b0)
  ) u_small (
    .clk         (clk),
    .rst         (rst),
    .pix_en      (pix_en),
    .hsync       (s_hs),
    .vsync       (s_vs),
    .de          (s_de),
    .line_start  (s_ls),
    .frame_start (s_fs)
`ifdef VTG_XY_OUT_EN
    ,
    .h_count     (s_h),
    .v_count     (s_v)
`endif
  );

  // Reference model: outputs follow directly from the position and the axis ranges.
  function automatic obs_t expect_of(mode_t m, mstate_t st);
    obs_t o;
    bit   in_hs, in_vs;
    in_hs = (st.h >= m.hv + m.hf) && (st.h < m.hv + m.hf + m.hsw);
    in_vs = (st.v >= m.vv + m.vf) && (st.v < m.vv + m.vf + m.vsw);
    o.hs = in_hs ? m.hp : !m.hp;
    o.vs = in_vs ? m.vp : !m.vp;
    o.de = (st.h < m.hv) && (st.v < m.vv);
    o.ls = st.ls;
    o.fs = st.fs;
`ifdef VTG_XY_OUT_EN
    o.h = CW'(st.h);
    o.v = CW'(st.v);
`else
    o.h = '0;
    o.v = '0;
`endif
    return o;
  endfunction

  function automatic mstate_t advance(mode_t m, mstate_t st, bit en);
    mstate_t n;
    int      ht, vt;
    ht = m.hv + m.hf + m.hsw + m.hb;
    vt = m.vv + m.vf + m.vsw + m.vb;
    n = st;
    n.ls = 1'b0;
    n.fs = 1'b0;
    if (en) begin
      n.h = st.h + 1;
      if (n.h == ht) begin
        n.h  = 0;
        n.ls = 1'b1;
        n.v  = st.v + 1;
        if (n.v == vt) begin
          n.v  = 0;
          n.fs = 1'b1;
        end
      end
    end
    return n;
  endfunction

  function automatic obs_t sample_dflt();
    obs_t o;
`ifdef VTG_XY_OUT_EN
    o = '{d_hs, d_vs, d_de, d_ls, d_fs, d_h, d_v};
`else
    o = '{d_hs, d_vs, d_de, d_ls, d_fs, {CW{1'b0}}, {CW{1'b0}}};
`endif
    return o;
  endfunction

  function automatic obs_t sample_small();
    obs_t o;
`ifdef VTG_XY_OUT_EN
    o = '{s_hs, s_vs, s_de, s_ls, s_fs, s_h, s_v};
`else
    o = '{s_hs, s_vs, s_de, s_ls, s_fs, {CW{1'b0}}, {CW{1'b0}}};
`endif
    return o;
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s @%0t: got hs=%b vs=%b de=%b ls=%b fs=%b h=%0d v=%0d, want hs=%b vs=%b de=%b ls=%b fs=%b h=%0d v=%0d",
               name, $time, act.hs, act.vs, act.de, act.ls, act.fs, act.h, act.v,
               exp.hs, exp.vs, exp.de, exp.ls, exp.fs, exp.h, exp.v);
    end else begin
      n_pass++;
    end
  endtask

  task automatic reset_model();
    st_d = '{h: 0, v: 0, ls: 1'b0, fs: 1'b0};
    st_s = '{h: 0, v: 0, ls: 1'b0, fs: 1'b0};
  endtask

  task automatic drive(input bit en);
    exp_t e;
    @(negedge clk);
    pix_en = en;
    st_d = advance(m_d, st_d, en);
    st_s = advance(m_s, st_s, en);
    e.d = expect_of(m_d, st_d);
    e.s = expect_of(m_s, st_s);
    exp_q.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
      exp_q.delete();
    end else begin
      n_pass++;
    end
  endtask

  task automatic check_reset_state(input string tag);
    mstate_t z;
    z = '{h: 0, v: 0, ls: 1'b0, fs: 1'b0};
    check({tag, "_dflt"}, sample_dflt(), expect_of(m_d, z));
    check({tag, "_small"}, sample_small(), expect_of(m_s, z));
  endtask

  // Monitor: compares one queued expectation per clock, just after the active edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("dflt", sample_dflt(), e.d);
        check("small", sample_small(), e.s);
      end
    end
  end

  initial begin
    m_d = '{hv: 640, hf: 16, hsw: 96, hb: 48, vv: 480, vf: 10, vsw: 2, vb: 33,
            hp: 1'b0, vp: 1'b0};
    m_s = '{hv: 4, hf: 1, hsw: 2, hb: 1, vv: 3, vf: 1, vsw: 1, vb: 1,
            hp: 1'b1, vp: 1'b0};
    reset_model();

    #23;
    check_reset_state("reset_init");
    @(negedge clk);
    rst = 1'b0;

    // Continuous enable: covers several full lines of the default mode (through v=11)
    // and many frames of the small mode.
    repeat (9000) drive(1'b1);

    // Alternating enable: line period doubles, outputs must hold on idle cycles.
    for (int i = 0; i < 3300; i++) drive(i % 2 == 0);

    repeat (3000) drive($urandom_range(0, 3) != 0);
    drain();

    // Asynchronous reset mid-frame, checked before the next clock edge.
    @(negedge clk);
    pix_en = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check_reset_state("reset_async");
    pix_en = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state("reset_hold");
    rst = 1'b0;
    reset_model();

    repeat (3) drive(1'b1);
    repeat (500) drive($urandom_range(0, 1) == 1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
